// File: rtl/mpc_pkg.sv
// rtl/mpc_pkg.sv - shared state type, config-register layout and defaults for the macro Wishbone router
package mpc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    FWD,
    DONE,
    ERR
  } state_t;

  localparam int CFG_SEL_LSB  = 0;
  localparam int CFG_MODE_BIT = 8;
  localparam int CFG_TOF_BIT  = 16;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

  // Width of the macro-select field; a single macro still needs one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mpc_wb_watchdog.sv
// rtl/mpc_wb_watchdog.sv - saturating per-transaction cycle counter flagging a hung macro
module mpc_wb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int            CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/mpc_wb_router.sv
// rtl/mpc_wb_router.sv - registered Wishbone fan-out/fan-in for an NH x NV grid of user macros
module mpc_wb_router
  import mpc_pkg::*;
#(
  parameter int          NH       = 2,
  parameter int          NV       = 2,
  parameter logic [31:0] CFG_ADDR = 32'h3000_0000,
  parameter int          SEL_LSB  = 20,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = DEFAULT_ERR_DATA,
  localparam int         N        = NH * NV,
  localparam int         SW       = sel_width(N)
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_dat_i,
  input  logic [31:0]     wbs_adr_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  output logic [N-1:0]    m_stb_o,
  output logic [N-1:0]    m_cyc_o,
  output logic            m_we_o,
  output logic [3:0]      m_sel_o,
  output logic [31:0]     m_dat_o,
  output logic [31:0]     m_adr_o,
  input  logic [N-1:0]    m_ack_i,
  input  logic [N*32-1:0] m_dat_i,
  output logic [SW-1:0]   configuration_o,
  output logic            mode_o,
  output logic            timeout_o
);

  localparam logic [SW:0] N_W = (SW + 1)'(N);

  state_t        r_state;
  logic          r_ack;
  logic [31:0]   r_dat;
  logic [N-1:0]  r_m_stb;
  logic          r_m_we;
  logic [3:0]    r_m_sel;
  logic [31:0]   r_m_dat;
  logic [31:0]   r_m_adr;
  logic [SW-1:0] r_active;
  logic          r_mode;
  logic          r_tof;

  logic          w_req;
  logic          w_cfg_hit;
  logic [SW-1:0] w_target;
  logic          w_bad_tgt;
  logic [N-1:0]  w_onehot;
  logic [SW-1:0] w_active_nxt;
  logic          w_mode_nxt;
  logic          w_tof_nxt;
  logic [31:0]   w_cfg_word;
  logic [31:0]   w_rdata;
  logic          w_tgt_ack;
  logic          w_expired;

  assign w_req     = wbs_cyc_i & wbs_stb_i;
  assign w_cfg_hit = (wbs_adr_i == CFG_ADDR);
  assign w_target  = r_mode ? wbs_adr_i[SEL_LSB +: SW] : r_active;
  assign w_bad_tgt = ({1'b0, w_target} >= N_W);
  assign w_onehot  = N'(1) << w_target;

  // Byte-lane write view of the config register; the timeout flag is write-1-to-clear.
  assign w_active_nxt = (wbs_we_i && wbs_sel_i[0]) ? wbs_dat_i[CFG_SEL_LSB +: SW] : r_active;
  assign w_mode_nxt   = (wbs_we_i && wbs_sel_i[1]) ? wbs_dat_i[CFG_MODE_BIT] : r_mode;
  assign w_tof_nxt    = r_tof & ~(wbs_we_i & wbs_sel_i[2] & wbs_dat_i[CFG_TOF_BIT]);

  always_comb begin
    w_cfg_word                        = '0;
    w_cfg_word[CFG_SEL_LSB +: SW]     = w_active_nxt;
    w_cfg_word[CFG_MODE_BIT]          = w_mode_nxt;
    w_cfg_word[CFG_TOF_BIT]           = w_tof_nxt;
  end

  // Strobe stays one-hot on the target while in FWD, so it doubles as the response select.
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < N; i++) begin
      if (r_m_stb[i]) w_rdata = w_rdata | m_dat_i[32*i +: 32];
    end
  end

  assign w_tgt_ack = |(m_ack_i & r_m_stb);

  mpc_wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .i_clr     (r_state != FWD),
    .i_en      (r_state == FWD),
    .o_expired (w_expired)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state  <= IDLE;
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_m_stb  <= '0;
      r_m_we   <= 1'b0;
      r_m_sel  <= '0;
      r_m_dat  <= '0;
      r_m_adr  <= '0;
      r_active <= '0;
      r_mode   <= 1'b0;
      r_tof    <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            if (w_cfg_hit) begin
              r_active <= w_active_nxt;
              r_mode   <= w_mode_nxt;
              r_tof    <= w_tof_nxt;
              r_dat    <= w_cfg_word;
              r_ack    <= 1'b1;
              r_state  <= CFG;
            end else if (w_bad_tgt) begin
              r_dat   <= ERR_DATA;
              r_ack   <= 1'b1;
              r_state <= ERR;
            end else begin
              r_m_stb <= w_onehot;
              r_m_we  <= wbs_we_i;
              r_m_sel <= wbs_sel_i;
              r_m_dat <= wbs_dat_i;
              r_m_adr <= wbs_adr_i;
              r_state <= FWD;
            end
          end
        end
        FWD: begin
          // Host abort beats everything; a target ack beats a same-cycle timeout.
          if (!wbs_cyc_i) begin
            r_m_stb <= '0;
            r_state <= IDLE;
          end else if (w_tgt_ack) begin
            r_m_stb <= '0;
            r_dat   <= w_rdata;
            r_ack   <= 1'b1;
            r_state <= DONE;
          end else if (w_expired) begin
            r_m_stb <= '0;
            r_tof   <= 1'b1;
            r_dat   <= ERR_DATA;
            r_ack   <= 1'b1;
            r_state <= ERR;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign wbs_ack_o       = r_ack;
  assign wbs_dat_o       = r_dat;
  assign m_stb_o         = r_m_stb;
  assign m_cyc_o         = r_m_stb;
  assign m_we_o          = r_m_we;
  assign m_sel_o         = r_m_sel;
  assign m_dat_o         = r_m_dat;
  assign m_adr_o         = r_m_adr;
  assign configuration_o = r_active;
  assign mode_o          = r_mode;
  assign timeout_o       = r_tof;

endmodule

// File: tb/tb_mpc_wb_router.sv
// tb/tb_mpc_wb_router.sv - directed self-checking bench for mpc_wb_router (2x2 and 3x1 instances)
module tb_mpc_wb_router;
  import mpc_pkg::*;

  localparam logic [31:0]  CFGA     = 32'h3000_0000;
  localparam logic [127:0] DAT_IDLE = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic          dut_sel = 1'b0;
  logic          h_cyc = 1'b0, h_stb = 1'b0, h_we = 1'b0;
  logic [3:0]    h_sel = 4'h0;
  logic [31:0]   h_dat = '0, h_adr = '0;
  logic [3:0]    h_m_ack = '0;
  logic [127:0]  h_m_dat = DAT_IDLE;

  logic          a_ack, a_m_we, a_mode, a_tof;
  logic [31:0]   a_rdat, a_m_dat, a_m_adr;
  logic [3:0]    a_stb, a_cyc, a_m_sel;
  logic [1:0]    a_cfg;

  logic          b_ack, b_m_we, b_mode, b_tof;
  logic [31:0]   b_rdat, b_m_dat, b_m_adr;
  logic [2:0]    b_stb, b_cyc;
  logic [3:0]    b_m_sel;
  logic [1:0]    b_cfg;

  logic          obs_ack;
  logic [31:0]   obs_rdat;
  logic [3:0]    obs_stb;

  assign obs_ack  = dut_sel ? b_ack  : a_ack;
  assign obs_rdat = dut_sel ? b_rdat : a_rdat;
  assign obs_stb  = dut_sel ? {1'b0, b_stb} : a_stb;

  mpc_wb_router #(.NH(2), .NV(2), .TIMEOUT(255)) u_dut_a (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .wbs_stb_i       (h_stb & ~dut_sel),
    .wbs_cyc_i       (h_cyc & ~dut_sel),
    .wbs_we_i        (h_we),
    .wbs_sel_i       (h_sel),
    .wbs_dat_i       (h_dat),
    .wbs_adr_i       (h_adr),
    .wbs_ack_o       (a_ack),
    .wbs_dat_o       (a_rdat),
    .m_stb_o         (a_stb),
    .m_cyc_o         (a_cyc),
    .m_we_o          (a_m_we),
    .m_sel_o         (a_m_sel),
    .m_dat_o         (a_m_dat),
    .m_adr_o         (a_m_adr),
    .m_ack_i         (dut_sel ? 4'b0000 : h_m_ack),
    .m_dat_i         (h_m_dat),
    .configuration_o (a_cfg),
    .mode_o          (a_mode),
    .timeout_o       (a_tof)
  );

  mpc_wb_router #(.NH(3), .NV(1), .TIMEOUT(4)) u_dut_b (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .wbs_stb_i       (h_stb & dut_sel),
    .wbs_cyc_i       (h_cyc & dut_sel),
    .wbs_we_i        (h_we),
    .wbs_sel_i       (h_sel),
    .wbs_dat_i       (h_dat),
    .wbs_adr_i       (h_adr),
    .wbs_ack_o       (b_ack),
    .wbs_dat_o       (b_rdat),
    .m_stb_o         (b_stb),
    .m_cyc_o         (b_cyc),
    .m_we_o          (b_m_we),
    .m_sel_o         (b_m_sel),
    .m_dat_o         (b_m_dat),
    .m_adr_o         (b_m_adr),
    .m_ack_i         (dut_sel ? h_m_ack[2:0] : 3'b000),
    .m_dat_i         (h_m_dat[95:0]),
    .configuration_o (b_cfg),
    .mode_o          (b_mode),
    .timeout_o       (b_tof)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One host transaction; cycle c is the cycle after request edge c-1, sampled at its negedge.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                      input logic [3:0] sel, input int t_idx, input int t_cyc,
                      input int nt_idx, input int nt_cyc, input int abort_cyc,
                      input logic [31:0] rdata, output logic [31:0] got, output int ack_cyc,
                      output logic [3:0] stb_or, output int stb_last);
    int limit;
    got      = '0;
    ack_cyc  = 0;
    stb_or   = '0;
    stb_last = 0;
    limit    = (abort_cyc > 0) ? abort_cyc + 3 : 400;
    @(negedge clk);
    h_cyc = 1'b1; h_stb = 1'b1; h_we = we; h_adr = adr; h_dat = wdat; h_sel = sel;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      h_m_ack = '0;
      h_m_dat = DAT_IDLE;
      if (|obs_stb) begin
        stb_or   = stb_or | obs_stb;
        stb_last = c;
      end
      if (obs_ack) begin
        ack_cyc = c;
        got     = obs_rdat;
        break;
      end
      if (c == abort_cyc) begin
        h_cyc = 1'b0; h_stb = 1'b0;
      end
      if (c == t_cyc) begin
        h_m_ack[t_idx]          = 1'b1;
        h_m_dat[32*t_idx +: 32] = rdata;
      end
      if (c == nt_cyc) h_m_ack[nt_idx] = 1'b1;
    end
    h_cyc = 1'b0; h_stb = 1'b0; h_we = 1'b0; h_m_ack = '0; h_m_dat = DAT_IDLE;
    @(negedge clk);
    check("ack_pulse", 32'(obs_ack), 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    int          ack_c;
    logic [3:0]  stb_or;
    int          stb_last;

    #3;
    check("rst_ack",  32'(a_ack), 32'd0);
    check("rst_rdat", a_rdat, 32'd0);
    check("rst_stb",  32'({a_stb, a_cyc}), 32'd0);
    check("rst_cfg",  32'({a_tof, a_mode, a_cfg}), 32'd0);
    check("rst_madr", a_m_adr, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    xfer(1'b0, 32'h1000_0004, 32'd0, 4'hF, 0, 4, -1, -1, 0, 32'h1234_5678, got, ack_c, stb_or, stb_last);
    check("single_data",   got, 32'h1234_5678);
    check("single_ackcyc", 32'(ack_c), 32'd5);
    check("single_stb",    32'(stb_or), 32'd1);
    check("single_stblast",32'(stb_last), 32'd4);
    check("single_madr",   a_m_adr, 32'h1000_0004);

    xfer(1'b1, CFGA, 32'h0000_0102, 4'hF, -1, -1, -1, -1, 0, 32'd0, got, ack_c, stb_or, stb_last);
    check("cfgw_ackcyc", 32'(ack_c), 32'd1);
    check("cfgw_stb",    32'(stb_or), 32'd0);
    check("cfgw_regs",   32'({a_tof, a_mode, a_cfg}), 32'd6);

    xfer(1'b0, CFGA, 32'd0, 4'hF, -1, -1, -1, -1, 0, 32'd0, got, ack_c, stb_or, stb_last);
    check("cfgr_data",   got, 32'h0000_0102);
    check("cfgr_ackcyc", 32'(ack_c), 32'd1);

    xfer(1'b0, 32'h0030_0000, 32'd0, 4'hF, 3, 1, -1, -1, 0, 32'hCAFE_0003, got, ack_c, stb_or, stb_last);
    check("dec_data",   got, 32'hCAFE_0003);
    check("dec_ackcyc", 32'(ack_c), 32'd2);
    check("dec_stb",    32'(stb_or), 32'h8);

    xfer(1'b0, 32'h0010_0000, 32'd0, 4'hF, 1, 5, 2, 2, 0, 32'h0BAD_F00D, got, ack_c, stb_or, stb_last);
    check("nt_data",    got, 32'h0BAD_F00D);
    check("nt_ackcyc",  32'(ack_c), 32'd6);
    check("nt_stb",     32'(stb_or), 32'h2);

    xfer(1'b0, 32'h0020_0000, 32'd0, 4'hF, -1, -1, -1, -1, 3, 32'd0, got, ack_c, stb_or, stb_last);
    check("abort_noack",  32'(ack_c), 32'd0);
    check("abort_stblast",32'(stb_last), 32'd3);
    check("abort_stb",    32'({a_stb, a_cyc}), 32'd0);

    xfer(1'b0, 32'h0000_0000, 32'd0, 4'hF, -1, -1, -1, -1, 0, 32'd0, got, ack_c, stb_or, stb_last);
    check("to_data",    got, 32'hDEAD_BEEF);
    check("to_ackcyc",  32'(ack_c), 32'd257);
    check("to_stblast", 32'(stb_last), 32'd256);
    check("to_flag",    32'(a_tof), 32'd1);

    xfer(1'b0, CFGA, 32'd0, 4'hF, -1, -1, -1, -1, 0, 32'd0, got, ack_c, stb_or, stb_last);
    check("to_cfgread", got, 32'h0001_0102);

    xfer(1'b1, CFGA, 32'h0001_0000, 4'h0, -1, -1, -1, -1, 0, 32'd0, got, ack_c, stb_or, stb_last);
    check("w1c_nosel", 32'({a_tof, a_mode, a_cfg}), 32'hE);
    xfer(1'b1, CFGA, 32'h0001_0000, 4'h4, -1, -1, -1, -1, 0, 32'd0, got, ack_c, stb_or, stb_last);
    check("w1c_clear", 32'({a_tof, a_mode, a_cfg}), 32'h6);

    @(negedge clk);
    h_cyc = 1'b1; h_stb = 1'b1; h_we = 1'b0; h_adr = 32'd0; h_sel = 4'hF;
    @(negedge clk);
    @(negedge clk);
    check("rmid_stb_pre", 32'(a_stb), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rmid_ack",  32'(a_ack), 32'd0);
    check("rmid_rdat", a_rdat, 32'd0);
    check("rmid_stb",  32'({a_stb, a_cyc}), 32'd0);
    check("rmid_cfg",  32'({a_tof, a_mode, a_cfg}), 32'd0);
    check("rmid_msel", 32'(a_m_sel), 32'd0);
    @(negedge clk);
    rst = 1'b0; h_cyc = 1'b0; h_stb = 1'b0;
    repeat (3) @(negedge clk);
    check("rmid_quiet", 32'({a_ack, a_stb}), 32'd0);

    dut_sel = 1'b1;
    check("b_rst_cfg", 32'({b_tof, b_mode, b_cfg}), 32'd0);
    xfer(1'b1, CFGA, 32'h0000_0100, 4'hF, -1, -1, -1, -1, 0, 32'd0, got, ack_c, stb_or, stb_last);
    check("b_mode", 32'(b_mode), 32'd1);

    xfer(1'b0, 32'h0030_0000, 32'd0, 4'hF, -1, -1, -1, -1, 0, 32'd0, got, ack_c, stb_or, stb_last);
    check("bad_data",   got, 32'hDEAD_BEEF);
    check("bad_ackcyc", 32'(ack_c), 32'd1);
    check("bad_stb",    32'(stb_or), 32'd0);
    check("bad_noflag", 32'(b_tof), 32'd0);

    xfer(1'b0, 32'h0020_0000, 32'd0, 4'hF, -1, -1, -1, -1, 0, 32'd0, got, ack_c, stb_or, stb_last);
    check("bto_data",    got, 32'hDEAD_BEEF);
    check("bto_ackcyc",  32'(ack_c), 32'd6);
    check("bto_stb",     32'(stb_or), 32'h4);
    check("bto_stblast", 32'(stb_last), 32'd5);
    check("bto_flag",    32'(b_tof), 32'd1);

    xfer(1'b0, 32'h0020_0000, 32'd0, 4'hF, 2, 5, -1, -1, 0, 32'h5A5A_1234, got, ack_c, stb_or, stb_last);
    check("race_data",   got, 32'h5A5A_1234);
    check("race_ackcyc", 32'(ack_c), 32'd6);

    xfer(1'b1, CFGA, 32'h0000_0003, 4'h3, -1, -1, -1, -1, 0, 32'd0, got, ack_c, stb_or, stb_last);
    check("b_cfg3", 32'({b_mode, b_cfg}), 32'd3);
    xfer(1'b0, 32'h0000_0000, 32'd0, 4'hF, -1, -1, -1, -1, 0, 32'd0, got, ack_c, stb_or, stb_last);
    check("sbad_data",   got, 32'hDEAD_BEEF);
    check("sbad_ackcyc", 32'(ack_c), 32'd1);
    check("sbad_stb",    32'(stb_or), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mpc_wb_router.md
# mpc_wb_router

Parametrised Wishbone fan-out/fan-in for an NH×NV grid of user macros in the multi-project chip. It replaces the fixed 2×2 configuration-driven bus select with a registered, software-programmable router. The router supports two modes: route every access to one active macro, or decode the target macro from address bits. A per-transaction watchdog terminates hung slaves with an error word. The router drives `configuration_o` to the pad-mux layer, which keeps pad routing consistent with the macro that owns the bus.

## Interface
Parameters:
- `NH`, 2, macro columns.
- `NV`, 2, macro rows. N = NH*NV; SW = max(1, clog2(N)).
- `CFG_ADDR`, 32'h3000_0000, word address of the internal config register.
- `SEL_LSB`, 20, LSB of the macro-select field in decode mode.
- `TIMEOUT`, 255, cycles to wait for a macro ack; must be ≥1.
- `ERR_DATA`, 32'hDEAD_BEEF, read data returned on timeout or bad target.

Ports:
- `wb_clk_i` in 1: the single clock.
- `wb_rst_i` in 1: reset, asynchronous, active-high.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1 each: host Wishbone strobe, cycle and write enable.
- `wbs_sel_i` in 4: host byte selects.
- `wbs_dat_i` in 32, `wbs_adr_i` in 32: host write data and address.
- `wbs_ack_o` out 1, `wbs_dat_o` out 32: host ack and read data.
- `m_stb_o`, `m_cyc_o` out N: per-macro strobe and cycle; one-hot or zero.
- `m_we_o` out 1, `m_sel_o` out 4, `m_dat_o` out 32, `m_adr_o` out 32: shared request bus, registered at launch.
- `m_ack_i` in N: per-macro acks.
- `m_dat_i` in N*32: macro i read data on bits [32i+31:32i].
- `configuration_o` out SW: active macro, to the pad mux.
- `mode_o` out 1: 0 = single, 1 = decode.
- `timeout_o` out 1: sticky error flag.

## Operation
- Config register layout: [SW-1:0] active macro; [8] mode; [16] timeout flag.
  - Bit 16 is set by hardware and cleared by writing 1 (W1C).
  - Writes honour `wbs_sel_i` per byte.
  - Other bits read 0.
- States:
  - IDLE:
    - On `wbs_cyc_i & wbs_stb_i` with `wbs_adr_i == CFG_ADDR` → CFG. A write updates the register on this edge.
    - Otherwise compute the target: mode 0 → active macro; mode 1 → `wbs_adr_i[SEL_LSB+SW-1:SEL_LSB]`.
    - If target ≥ N → ERR.
    - Else latch the target and request fields, assert `m_cyc_o/m_stb_o[target]` → FWD.
  - CFG: `wbs_ack_o`=1 and `wbs_dat_o`=register value → IDLE.
  - FWD:
    - Watchdog counts cycles in FWD.
    - `m_ack_i[target]` → capture `m_dat_i` slice, drop `m_stb_o/m_cyc_o` → DONE.
    - Count reaches TIMEOUT with no ack → drop strobes, set the timeout flag → ERR.
    - `wbs_cyc_i` deasserted by the host → drop strobes → IDLE with no ack (abort).
  - DONE: `wbs_ack_o`=1 with the captured data → IDLE.
  - ERR: `wbs_ack_o`=1, `wbs_dat_o`=ERR_DATA → IDLE.
- Acks from non-target macros are ignored.
- An ack and a timeout in the same cycle: the ack wins.
- `configuration_o`/`mode_o` change only on a CFG write, so a forwarded transaction never sees a routing change mid-flight.

## Timing
- All outputs are registered.
- Reset values: every output 0; config register 0 (macro 0, single mode, flag clear); state IDLE.
- Reset mid-transaction returns to IDLE within the same cycle (async), drops all strobes, and produces no host ack.
- CFG access: request sampled at edge 0 → `wbs_ack_o` high during cycle 1, for exactly one cycle.
- Forward: request sampled at edge 0 → `m_stb_o` high from cycle 1; macro ack sampled at edge k → `wbs_ack_o` high for cycle k+1. Round trip is 2 cycles minimum.
- Timeout: no ack for TIMEOUT cycles in FWD → error ack at cycle TIMEOUT+2 after the request.
- `wbs_ack_o` is a single-cycle pulse. The host must deassert `wbs_stb_i` the cycle after the ack; IDLE re-samples afterwards.

## Structure
- `mpc_pkg`: state enum (IDLE, CFG, FWD, DONE, ERR); config bit positions (SEL, MODE=8, TOF=16); default ERR_DATA.
- Sub-module `mpc_wb_watchdog`: clear/enable counter with a `expired` output, width clog2(TIMEOUT+1).

## Test plan
- Single mode, reset config: read 0x1000_0004; macro 0 acks 3 cycles after `m_stb_o` with 0x1234_5678 → only `m_stb_o[0]` asserts; host sees 0x1234_5678 one cycle after the macro ack.
- Write 0x0000_0102 to CFG_ADDR → next-cycle ack; `configuration_o`=2, `mode_o`=1; readback 0x0000_0102.
- Decode mode, address 0x0030_0000 → `m_stb_o`=4'b1000; address with select field ≥ N (set NH=3, NV=1, field 3) → immediate ERR_DATA ack, no macro strobe.
- Macro never acks → `m_stb_o` drops after 255 cycles; host gets 0xDEAD_BEEF; `timeout_o`=1; W1C write of bit 16 clears it.
- Host drops `wbs_cyc_i` in FWD → strobes fall next edge, no `wbs_ack_o`. `wb_rst_i` pulse in FWD → all outputs 0 immediately.
- Non-target macro ack asserted in FWD → ignored; the transaction completes only on the target's ack.
